matrix_loader: RTL and testbench
================================

Name: matrix_loader

Overview:
- Parametrised serial-to-parallel operand loader for the array multiplier datapath.
- Accepts a stream of DATA_W-bit words over a valid/ready handshake and fills two N x N operand matrices, A first, then B.
- Presents both matrices as flat buses and holds them with done asserted until the downstream multiplier acknowledges them.
- Adds selectable column-major ordering for B, abort, backpressure and a sticky drop-error flag.

Parameters:
- DATA_W, 8: element width in bits (>=1).
- N, 3: matrix dimension; each matrix holds N*N elements (N>=1).
- CW, $clog2(2*N*N) (minimum 1): width of the beat counter; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset (sampled on clk rising edge).
- s_data  in  DATA_W  input element.
- s_valid  in  1  s_data valid.
- s_ready  out  1  loader can accept a beat; equals !done.
- b_col_major  in  1  B ordering mode: 0 = row-major, 1 = column-major; sampled on the first beat of each frame.
- abort  in  1  discard the partial or complete frame.
- mat_ack  in  1  downstream has consumed the matrices.
- done  out  1  both matrices complete and stable.
- load_cnt  out  CW  beats accepted in the current frame.
- drop_err  out  1  sticky: s_valid was high while s_ready was low.
- a_flat  out  N*N*DATA_W  element A[r][c] at bits [(r*N+c)*DATA_W +: DATA_W].
- b_flat  out  N*N*DATA_W  element B[r][c] at bits [(r*N+c)*DATA_W +: DATA_W].

Behaviour:
- Reset (reset==0 at a clk edge) has the highest priority. It sets:
  - all A and B elements to 0;
  - load_cnt, done, drop_err and the latched mode to 0.
  - s_ready is therefore 1 in the cycle after reset.
- Beat acceptance and frame order:
  - A beat is accepted when s_valid && s_ready at a clk edge.
  - Beat k (k = load_cnt) with k < N*N writes A[k/N][k%N]; A is always row-major.
  - Beat k >= N*N uses j = k - N*N:
    - mode 0 writes B[j/N][j%N];
    - mode 1 writes B[j%N][j/N].
- Mode latch:
  - b_col_major is latched on the accepted beat with load_cnt == 0, and that beat uses the newly sampled value.
  - Later changes to b_col_major within the frame are ignored.
- Counter:
  - Increments on each accepted beat.
  - On the accepted beat with load_cnt == 2*N*N-1, load_cnt returns to 0 and done goes to 1 on the same edge.
  - Latency: done is visible the cycle after the last beat; a_flat and b_flat are valid in that same cycle.
- Hold:
  - While done==1, s_ready==0 and the matrices do not change.
  - mat_ack is ignored while done==0.
  - mat_ack with done==1 clears done on that edge, so s_ready==1 the next cycle and the next frame starts at load_cnt==0.
  - Matrices keep their old contents until overwritten.
- Abort (after reset, above all else):
  - Sets load_cnt to 0 and done to 0.
  - A beat presented in the same cycle is discarded, and drop_err is not set by it.
  - Matrix contents are retained.
  - Abort with done==1 releases the hold exactly like mat_ack.
- drop_err:
  - Set when s_valid && !s_ready && !abort.
  - Cleared only by reset or by mat_ack while done==1.
  - If set and clear coincide, set wins.
- Simultaneous mat_ack and s_valid with done==1: the beat is not accepted (s_ready is 0 that cycle), drop_err is set, then done clears.
- No combinational path from s_valid to s_ready.

Test Plan (N=3, DATA_W=8):
- Reset, then stream 1..18 with b_col_major=0 and continuous valid:
  - done rises one cycle after beat 18;
  - a_flat element 0 = 1 and element 8 = 9;
  - b_flat element 0 = 10 and element 8 = 18;
  - load_cnt = 0 when done rises.
- Column-major B: stream 1..18 with b_col_major=1 on beat 1, toggle it afterwards:
  - B[0][1]=13, B[1][0]=11, B[2][1]=15;
  - A is unchanged by the mode.
- Backpressure: after done, hold s_valid=1 with data 0xFF for 3 cycles:
  - s_ready stays 0, the matrices are unchanged and drop_err=1.
  - mat_ack then clears done and drop_err; the next beat 0x55 lands in A[0][0].
- Abort mid-frame: abort after 5 beats, together with a valid beat 0xAA:
  - load_cnt=0, 0xAA is not written, drop_err stays 0.
  - Restarting 1..18 gives the same results as the first scenario.
- Reset mid-frame: assert reset for 1 cycle after beat 12:
  - all elements are 0, load_cnt=0, done=0, s_ready=1 the next cycle.
- Bubbles: stream 18 beats with s_valid low on alternate cycles:
  - results match the first scenario;
  - done rises exactly one cycle after the 18th accepted beat.

Source files
------------

// File: rtl/matrix_loader.sv
// Serial-to-parallel operand loader: streams N*N elements of A (row-major),
// then N*N elements of B (row- or column-major), and holds both until acknowledged.
module matrix_loader #(
  parameter int DATA_W = 8,
  parameter int N      = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_W-1:0]          s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic                       b_col_major,
  input  logic                       abort,
  input  logic                       mat_ack,
  output logic                       done,
  output logic [$clog2(2*N*N)-1:0]   load_cnt,
  output logic                       drop_err,
  output logic [N*N*DATA_W-1:0]      a_flat,
  output logic [N*N*DATA_W-1:0]      b_flat
);

  localparam int NN  = N * N;
  localparam int TOT = 2 * NN;
  localparam int CW  = $clog2(TOT);
  localparam int IW  = (NN > 1) ? $clog2(NN) : 1;

  typedef enum logic {ST_LOAD, ST_HOLD} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              drop_q, drop_d;
  logic              mode_q, mode_d;
  logic              mode_eff;
  logic              a_we, b_we;
  logic [IW-1:0]     wr_idx;
  logic [DATA_W-1:0] a_q [NN];
  logic [DATA_W-1:0] b_q [NN];

  // Storage slot for beat k; B beats are transposed in column-major mode.
  function automatic logic [IW-1:0] elem_idx(input logic [CW-1:0] k, input logic col_major);
    int ki;
    int j;
    int idx;
    ki = int'(k);
    if (ki < NN) begin
      idx = ki;
    end else begin
      j   = ki - NN;
      idx = col_major ? ((j % N) * N + j / N) : j;
    end
    return IW'(idx);
  endfunction

  assign done     = (state_q == ST_HOLD);
  assign s_ready  = (state_q == ST_LOAD);
  assign load_cnt = cnt_q;
  assign drop_err = drop_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    drop_d   = drop_q;
    mode_d   = mode_q;
    a_we     = 1'b0;
    b_we     = 1'b0;
    wr_idx   = '0;
    // The first beat of a frame uses the freshly sampled mode.
    mode_eff = (cnt_q == '0) ? b_col_major : mode_q;

    if ((state_q == ST_HOLD) && mat_ack) drop_d = 1'b0;
    if ((state_q == ST_HOLD) && s_valid && !abort) drop_d = 1'b1;

    if (abort) begin
      cnt_d   = '0;
      state_d = ST_LOAD;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (mat_ack) state_d = ST_LOAD;
        end
        ST_LOAD: begin
          if (s_valid) begin
            mode_d = mode_eff;
            wr_idx = elem_idx(cnt_q, mode_eff);
            if (int'(cnt_q) < NN) a_we = 1'b1;
            else                  b_we = 1'b1;
            if (cnt_q == CW'(TOT - 1)) begin
              cnt_d   = '0;
              state_d = ST_HOLD;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: state_d = ST_LOAD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_LOAD;
      cnt_q   <= '0;
      drop_q  <= 1'b0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
      mode_q  <= mode_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NN; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
      end
    end else begin
      if (a_we) a_q[wr_idx] <= s_data;
      if (b_we) b_q[wr_idx] <= s_data;
    end
  end

  for (genvar e = 0; e < NN; e++) begin : g_flat
    assign a_flat[e*DATA_W +: DATA_W] = a_q[e];
    assign b_flat[e*DATA_W +: DATA_W] = b_q[e];
  end

endmodule

// File: tb/tb_matrix_loader.sv
// Directed bench for matrix_loader (N=3, DATA_W=8) with a cycle-level reference model.
module tb_matrix_loader;

  localparam int DATA_W = 8;
  localparam int N      = 3;
  localparam int NN     = N * N;
  localparam int CW     = 5;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [DATA_W-1:0] s_data = '0;
  logic              s_valid = 1'b0;
  logic              b_col_major = 1'b0;
  logic              abort = 1'b0;
  logic              mat_ack = 1'b0;
  logic              s_ready;
  logic              done;
  logic [CW-1:0]     load_cnt;
  logic              drop_err;
  logic [NN*DATA_W-1:0] a_flat;
  logic [NN*DATA_W-1:0] b_flat;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  logic [7:0] ma [N][N];
  logic [7:0] mb [N][N];
  bit m_done, m_drop, m_mode, was_done;
  int m_cnt, j;

  always #5 clk = ~clk;

  matrix_loader #(.DATA_W(DATA_W), .N(N)) dut (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .b_col_major(b_col_major), .abort(abort), .mat_ack(mat_ack), .done(done),
    .load_cnt(load_cnt), .drop_err(drop_err), .a_flat(a_flat), .b_flat(b_flat)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [71:0] flat_a();
    logic [71:0] f;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) f[(r*N+c)*8 +: 8] = ma[r][c];
    return f;
  endfunction

  function automatic logic [71:0] flat_b();
    logic [71:0] f;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) f[(r*N+c)*8 +: 8] = mb[r][c];
    return f;
  endfunction

  function automatic logic [7:0] el(input logic [71:0] f, input int e);
    return f[e*8 +: 8];
  endfunction

  // Reference model: frame rules applied to plain 2-D arrays.
  always @(posedge clk) begin
    if (!reset) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) begin
          ma[r][c] = 8'h00;
          mb[r][c] = 8'h00;
        end
      m_done = 0; m_drop = 0; m_mode = 0; m_cnt = 0;
    end else begin
      was_done = m_done;
      if (was_done && mat_ack) m_drop = 0;
      if (s_valid && was_done && !abort) m_drop = 1;
      if (abort) begin
        m_cnt = 0;
        m_done = 0;
      end else if (was_done) begin
        if (mat_ack) m_done = 0;
      end else if (s_valid) begin
        if (m_cnt == 0) m_mode = b_col_major;
        if (m_cnt < NN) ma[m_cnt / N][m_cnt % N] = s_data;
        else begin
          j = m_cnt - NN;
          if (m_mode) mb[j % N][j / N] = s_data;
          else        mb[j / N][j % N] = s_data;
        end
        m_cnt++;
        if (m_cnt == 2 * NN) begin
          m_cnt = 0;
          m_done = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("s_ready", 128'(s_ready), 128'(!m_done));
      chk("done", 128'(done), 128'(m_done));
      chk("load_cnt", 128'(load_cnt), 128'(m_cnt));
      chk("drop_err", 128'(drop_err), 128'(m_drop));
      chk("a_flat", 128'(a_flat), 128'(flat_a()));
      chk("b_flat", 128'(b_flat), 128'(flat_b()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    s_valid = 1'b1;
    s_data  = d;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic ack();
    mat_ack = 1'b1;
    tick();
    mat_ack = 1'b0;
  endtask

  task automatic stream(input bit col, input bit toggle);
    for (int i = 1; i <= 2 * NN; i++) begin
      if (i == 1) b_col_major = col;
      else if (toggle) b_col_major = ~b_col_major;
      send(8'(i));
      if (i == 2 * NN - 1) chk("done_before_last", 128'(done), 128'(0));
    end
    chk("done_after_last", 128'(done), 128'(1));
    chk("cnt_at_done", 128'(load_cnt), 128'(0));
  endtask

  task automatic check_first_result(input string tag);
    chk({tag, "_a0"}, 128'(el(a_flat, 0)), 128'(1));
    chk({tag, "_a8"}, 128'(el(a_flat, 8)), 128'(9));
    chk({tag, "_b0"}, 128'(el(b_flat, 0)), 128'(10));
    chk({tag, "_b1"}, 128'(el(b_flat, 1)), 128'(11));
    chk({tag, "_b8"}, 128'(el(b_flat, 8)), 128'(18));
  endtask

  initial begin
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    chk_en = 1'b1;
    chk("rst_ready", 128'(s_ready), 128'(1));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_a", 128'(a_flat), 128'(0));

    // Row-major frame with continuous valid
    stream(1'b0, 1'b0);
    check_first_result("rowmaj");
    chk("model_a22", 128'(ma[2][2]), 128'(9));
    chk("model_b00", 128'(mb[0][0]), 128'(10));
    ack();
    chk("ack_done", 128'(done), 128'(0));

    // Column-major B, mode toggled after the first beat
    stream(1'b1, 1'b1);
    chk("colmaj_b01", 128'(el(b_flat, 1)), 128'(13));
    chk("colmaj_b10", 128'(el(b_flat, 3)), 128'(11));
    chk("colmaj_b21", 128'(el(b_flat, 7)), 128'(15));
    chk("colmaj_a0", 128'(el(a_flat, 0)), 128'(1));
    chk("colmaj_a8", 128'(el(a_flat, 8)), 128'(9));
    chk("model_b01", 128'(mb[0][1]), 128'(13));

    // Backpressure while holding
    s_valid = 1'b1;
    s_data  = 8'hFF;
    repeat (3) tick();
    chk("bp_ready", 128'(s_ready), 128'(0));
    chk("bp_drop", 128'(drop_err), 128'(1));
    chk("bp_a0", 128'(el(a_flat, 0)), 128'(1));
    chk("bp_b1", 128'(el(b_flat, 1)), 128'(13));
    s_valid = 1'b0;
    ack();
    chk("bp_ack_done", 128'(done), 128'(0));
    chk("bp_ack_drop", 128'(drop_err), 128'(0));
    chk("bp_ack_ready", 128'(s_ready), 128'(1));
    send(8'h55);
    chk("next_a0", 128'(el(a_flat, 0)), 128'(8'h55));
    chk("next_cnt", 128'(load_cnt), 128'(1));

    // Abort mid-frame together with a valid beat
    abort = 1'b1;
    tick();
    abort = 1'b0;
    b_col_major = 1'b0;
    for (int i = 1; i <= 5; i++) send(8'(i));
    chk("pre_abort_cnt", 128'(load_cnt), 128'(5));
    abort   = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'hAA;
    tick();
    abort   = 1'b0;
    s_valid = 1'b0;
    chk("abort_cnt", 128'(load_cnt), 128'(0));
    chk("abort_a5", 128'(el(a_flat, 5)), 128'(6));
    chk("abort_drop", 128'(drop_err), 128'(0));
    stream(1'b0, 1'b0);
    check_first_result("restart");
    ack();

    // Reset in the middle of a frame
    for (int i = 1; i <= 12; i++) send(8'(i));
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("mrst_a", 128'(a_flat), 128'(0));
    chk("mrst_b", 128'(b_flat), 128'(0));
    chk("mrst_cnt", 128'(load_cnt), 128'(0));
    chk("mrst_done", 128'(done), 128'(0));
    chk("mrst_ready", 128'(s_ready), 128'(1));

    // Bubbles on alternate cycles
    b_col_major = 1'b0;
    for (int i = 1; i <= 2 * NN; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(i);
      tick();
      s_valid = 1'b0;
      chk("bubble_done", 128'(done), 128'(i == 2 * NN));
      if (i != 2 * NN) tick();
    end
    check_first_result("bubble");
    ack();
    chk("final_done", 128'(done), 128'(0));
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
